// File: rtl/commit_trace_tx.sv
// Retirement-trace transmitter: one valid/ready frame (PC, instruction, r0..r31) per new IR value.
// Optional frame sequence word enabled by defining COMMIT_TRACE_SEQ_EN.
module commit_trace_tx (
  input  logic        clk,
  input  logic        reset,
  input  logic        trace_en,
  input  logic [31:0] ir_out,
  input  logic [31:0] pc_out,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic        trace_hold,
  output logic [31:0] trace_data,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic        trace_last
);

  // state    | meaning
  // ST_IDLE  | waiting for a new instruction word in ir_out
  // ST_SEQ   | presenting {A5A5, seq} (only with COMMIT_TRACE_SEQ_EN)
  // ST_PC    | presenting captured PC
  // ST_INSTR | presenting captured (retired) instruction word
  // ST_REGS  | presenting regfile word k, k = 0..31
`ifdef COMMIT_TRACE_SEQ_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEQ   = 3'd1,
    ST_PC    = 3'd2,
    ST_INSTR = 3'd3,
    ST_REGS  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PC    = 3'd2,
    ST_INSTR = 3'd3,
    ST_REGS  = 3'd4
  } state_t;
`endif

  state_t      state, state_nxt;
  logic [31:0] prev_instr;
  logic [31:0] pc_cap;
  logic [31:0] instr_cap;
  logic [4:0]  k;
  logic        busy_q;
  logic        xfer;
  logic        trigger;
`ifdef COMMIT_TRACE_SEQ_EN
  logic [15:0] seq;
`endif

  assign xfer    = busy_q && trace_ready;
  assign trigger = (state == ST_IDLE) && trace_en && (ir_out != prev_instr);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (trigger) begin
`ifdef COMMIT_TRACE_SEQ_EN
          state_nxt = ST_SEQ;
`else
          state_nxt = ST_PC;
`endif
        end
      end
`ifdef COMMIT_TRACE_SEQ_EN
      ST_SEQ:   if (xfer) state_nxt = ST_PC;
`endif
      ST_PC:    if (xfer) state_nxt = ST_INSTR;
      ST_INSTR: if (xfer) state_nxt = ST_REGS;
      ST_REGS:  if (xfer && (k == 5'd31)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // valid/hold come straight from a flop so the CPU stall request is glitch-free
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      busy_q     <= 1'b0;
      prev_instr <= 32'd0;
      pc_cap     <= 32'd0;
      instr_cap  <= 32'd0;
      k          <= 5'd0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != ST_IDLE);
      if (trigger) begin
        pc_cap     <= pc_out - 32'd8;
        instr_cap  <= prev_instr;
        prev_instr <= ir_out;
      end
      if ((state == ST_INSTR) && xfer) begin
        k <= 5'd0;
      end else if ((state == ST_REGS) && xfer) begin
        k <= k + 5'd1;
      end
    end
  end

`ifdef COMMIT_TRACE_SEQ_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq <= 16'd0;
    end else if ((state == ST_SEQ) && xfer) begin
      seq <= seq + 16'd1;
    end
  end
`endif

  always_comb begin
    trace_data = 32'd0;
    case (state)
`ifdef COMMIT_TRACE_SEQ_EN
      ST_SEQ:   trace_data = {16'hA5A5, seq};
`endif
      ST_PC:    trace_data = pc_cap;
      ST_INSTR: trace_data = instr_cap;
      ST_REGS:  trace_data = rf_rdata;
      default:  trace_data = 32'd0;
    endcase
  end

  assign trace_valid = busy_q;
  assign trace_hold  = busy_q;
  assign trace_last  = (state == ST_REGS) && (k == 5'd31);
  assign rf_raddr    = (state == ST_REGS) ? k : 5'd0;

endmodule

// File: tb/tb_commit_trace_tx.sv
// Self-checking bench for commit_trace_tx: queue-of-expected-words model plus directed and random stimulus.
module tb_commit_trace_tx;

`ifdef COMMIT_TRACE_SEQ_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 0;
`endif
  localparam int FLEN = 34 + OFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        trace_en;
  logic [31:0] ir_out;
  logic [31:0] pc_out;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        trace_hold;
  logic [31:0] trace_data;
  logic        trace_valid;
  logic        trace_ready;
  logic        trace_last;

  logic [31:0] rf [32];
  assign rf_rdata = rf[rf_raddr];

  always #5 clk = ~clk;

  commit_trace_tx dut (
    .clk         (clk),
    .reset       (reset),
    .trace_en    (trace_en),
    .ir_out      (ir_out),
    .pc_out      (pc_out),
    .rf_raddr    (rf_raddr),
    .rf_rdata    (rf_rdata),
    .trace_hold  (trace_hold),
    .trace_data  (trace_data),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_last  (trace_last)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [4:0]  raddr;
    logic        is_seq;
  } word_t;

  word_t       exp_q[$];
  logic [31:0] m_prev = 32'd0;
  logic [15:0] m_seq = 16'd0;
  int          frames_done = 0;
  int          words_in_frame = 0;
  int          hold_cycles = 0;
  int          last_hold_cycles = 0;
  logic [31:0] frame_log [FLEN];
  logic [31:0] seq_log[$];

  // A frame is fully determined the moment it triggers: regfile is frozen by trace_hold.
  task automatic push_frame();
    word_t w;
    if (OFF == 1) begin
      w.data = {16'hA5A5, m_seq}; w.last = 1'b0; w.raddr = 5'd0; w.is_seq = 1'b1;
      exp_q.push_back(w);
    end
    w.data = pc_out - 32'd8; w.last = 1'b0; w.raddr = 5'd0; w.is_seq = 1'b0;
    exp_q.push_back(w);
    w.data = m_prev;
    exp_q.push_back(w);
    for (int i = 0; i < 32; i++) begin
      w.data = rf[i]; w.last = (i == 31); w.raddr = 5'(i);
      exp_q.push_back(w);
    end
    m_prev = ir_out;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("rst_data", trace_data, 32'd0);
      check("rst_ctrl", 32'({trace_valid, trace_hold, trace_last, rf_raddr}), 32'd0);
      exp_q.delete();
      m_prev = 32'd0;
      m_seq = 16'd0;
      words_in_frame = 0;
      hold_cycles = 0;
    end else begin
      check("valid", 32'(trace_valid), 32'(exp_q.size() != 0));
      check("hold", 32'(trace_hold), 32'(exp_q.size() != 0));
      if (trace_hold) hold_cycles++;
      if (exp_q.size() != 0 && trace_valid) begin
        check("data", trace_data, exp_q[0].data);
        check("last", 32'(trace_last), 32'(exp_q[0].last));
        check("raddr", 32'(rf_raddr), 32'(exp_q[0].raddr));
        if (trace_ready) begin
          if (words_in_frame < FLEN) frame_log[words_in_frame] = trace_data;
          words_in_frame++;
          if (exp_q[0].is_seq) begin
            seq_log.push_back(trace_data);
            m_seq = m_seq + 16'd1;
          end
          if (exp_q[0].last) begin
            frames_done++;
            last_hold_cycles = hold_cycles;
            hold_cycles = 0;
            words_in_frame = 0;
          end
          void'(exp_q.pop_front());
        end
      end else if (exp_q.size() == 0) begin
        check("idle_last", 32'(trace_last), 32'd0);
      end
      if (exp_q.size() == 0 && trace_en && ir_out != m_prev) push_frame();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int target, input string name);
    int n = 0;
    while (frames_done < target && n < 3000) begin
      step();
      n++;
    end
    if (frames_done < target) check({name, "_timeout"}, 32'(frames_done), 32'(target));
  endtask

  initial begin
    int base;
    int n;
    reset = 1'b1; trace_en = 1'b1; trace_ready = 1'b1; ir_out = 32'd0; pc_out = 32'd0;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h01010101;
    #1 reset = 1'b0;
    #1 check("rst_async_valid", 32'(trace_valid), 32'd0);
    check("rst_async_data", trace_data, 32'd0);
    repeat (3) step();
    reset = 1'b1;

    // ir_out equal to the reset prev_instr: nothing to trace
    repeat (6) step();
    check("ir0_no_frame", 32'(frames_done), 32'd0);
    check("ir0_no_valid", 32'(trace_valid), 32'd0);

    ir_out = 32'h20080005; pc_out = 32'h00400008;
    wait_frames(1, "first");
    check("f1_pc", frame_log[OFF], 32'h00400000);
    check("f1_instr", frame_log[OFF+1], 32'h00000000);
    check("f1_r5", frame_log[OFF+2+5], 32'h05050505);
    check("f1_r31", frame_log[OFF+2+31], 32'h1F1F1F1F);
    check("f1_hold_cycles", 32'(last_hold_cycles), 32'(FLEN));

    // trace_en low blocks the trigger; raising it starts a frame on the next edge
    trace_en = 1'b0; ir_out = 32'h12345678; pc_out = 32'h00400010;
    repeat (5) step();
    check("en0_no_frame", 32'(frames_done), 32'd1);
    check("en0_no_valid", 32'(trace_valid), 32'd0);
    trace_en = 1'b1;
    step();
    check("en1_valid", 32'(trace_valid), 32'd1);
    wait_frames(2, "en");
    check("f2_pc", frame_log[OFF], 32'h00400008);
    check("f2_instr", frame_log[OFF+1], 32'h20080005);

    // 1-0-0-1 backpressure across the whole frame
    ir_out = 32'hDEADBEEF; pc_out = 32'h00400100;
    n = 0;
    while (frames_done < 3 && n < 3000) begin
      trace_ready = (n % 4 == 0) || (n % 4 == 3);
      step();
      n++;
    end
    check("bp_done", 32'(frames_done), 32'd3);
    check("bp_instr", frame_log[OFF+1], 32'h12345678);
    trace_ready = 1'b1;

`ifdef COMMIT_TRACE_SEQ_EN
    check("seq0", seq_log[0], 32'hA5A50000);
    check("seq1", seq_log[1], 32'hA5A50001);
    check("seq2", seq_log[2], 32'hA5A50002);
`endif

    // reset pulled mid-frame at word 10 aborts it
    ir_out = 32'hCAFEF00D; pc_out = 32'h00400200;
    n = 0;
    while (words_in_frame < 10 && n < 200) begin
      step();
      n++;
    end
    check("abort_reached", 32'(words_in_frame), 32'd10);
    reset = 1'b0;
    #1;
    check("abort_valid", 32'(trace_valid), 32'd0);
    check("abort_hold", 32'(trace_hold), 32'd0);
    check("abort_data", trace_data, 32'd0);
    ir_out = 32'd0;
    repeat (2) step();
    reset = 1'b1;
    base = frames_done;
    repeat (4) step();
    check("post_rst_idle", 32'(frames_done), 32'(base));
    ir_out = 32'h00000001; pc_out = 32'h00400308;
    wait_frames(base + 1, "post_rst");
    check("post_rst_pc", frame_log[OFF], 32'h00400300);
    check("post_rst_instr", frame_log[OFF+1], 32'h00000000);

    // random traffic: CPU side only moves while not held
    for (int c = 0; c < 4000; c++) begin
      trace_ready = ($urandom_range(3) != 0);
      trace_en = ($urandom_range(7) != 0);
      if (!trace_hold) begin
        if ($urandom_range(2) == 0) ir_out = ($urandom_range(3) == 0) ? ir_out : $urandom;
        pc_out = $urandom;
        rf[$urandom_range(31)] = $urandom;
      end
      step();
    end
    trace_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    check("random_frames_seen", 32'(frames_done > base + 20), 32'd1);

`ifdef COMMIT_TRACE_SEQ_EN
    step();
    force dut.seq = 16'hFFFF;
    m_seq = 16'hFFFF;
    step();
    release dut.seq;
    n = seq_log.size();
    ir_out = ir_out + 32'd1;
    wait_frames(frames_done + 1, "wrap1");
    ir_out = ir_out + 32'd1;
    wait_frames(frames_done + 1, "wrap2");
    check("seq_ffff", seq_log[n], 32'hA5A5FFFF);
    check("seq_wrap", seq_log[n+1], 32'hA5A50000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/commit_trace_tx.md
# commit_trace_tx

Retirement-trace transmitter for the MIPS54 multicycle SoC. It watches the CPU instruction register and detects each new instruction. For every one it emits a frame on a valid/ready word stream: the PC, the retired instruction word, and all 32 general registers. It stalls the CPU for the whole frame so the register snapshot is coherent, and lets an external trace sink or bench capture execution state without probing hierarchy.

## Interface
- No parameters; frame length is fixed by configuration.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `trace_en`  in  1  enables new frames; sampled only in IDLE.
- `ir_out`  in  32  CPU instruction register output.
- `pc_out`  in  32  CPU PC register output.
- `rf_raddr`  out  5  regfile debug read address.
- `rf_rdata`  in  32  regfile debug read data, combinational from `rf_raddr`.
- `trace_hold`  out  1  CPU stall request; CPU must freeze PC, IR and regfile writes while high.
- `trace_data`  out  32  stream word.
- `trace_valid`  out  1  `trace_data` is valid.
- `trace_ready`  in  1  sink accepts the word.
- `trace_last`  out  1  marks the final word of a frame.

## Operation
- Internal `prev_instr[31:0]` resets to 0.
- **Trigger:** state IDLE, `trace_en`=1, `ir_out` != `prev_instr`.
  - On the trigger edge: latch `pc_cap <= pc_out - 32'd8` (mod 2^32), `instr_cap <= prev_instr`, `prev_instr <= ir_out`.
- An instruction word equal to its predecessor never triggers. Consecutive identical words produce one frame.
- Frame words in order:
  - PC: `pc_cap`.
  - INSTR: `instr_cap`.
  - REGS: 32 words, index k=0..31, `trace_data = rf_rdata`, `rf_raddr = k`.
- FSM transitions:
  - IDLE→PC on trigger.
  - PC→INSTR on handshake.
  - INSTR→REGS on handshake, with k=0.
  - REGS: k increments on each handshake. The handshake at k=31 returns to IDLE.
- A 5-bit counter `k` is used. `rf_raddr` = k in REGS and 0 elsewhere.
- Handshake: a word transfers on a rising edge with `trace_valid` && `trace_ready`.
  - `trace_data`, `trace_last` and `rf_raddr` must stay stable while `trace_valid`=1 and `trace_ready`=0.
  - Stability of `rf_rdata` comes from `trace_hold`.
- `trace_valid` = (state != IDLE). `trace_hold` = (state != IDLE). `trace_last` = REGS && k==31.
- `trace_en` deasserted mid-frame has no effect; the frame completes.
- `ir_out` changes while not IDLE are ignored, but must not happen while `trace_hold`=1.
- Reset asserted mid-frame aborts the frame immediately. No partial-frame recovery is done.

## Timing
- Reset values:
  - `trace_valid`=0, `trace_hold`=0, `trace_last`=0, `trace_data`=0, `rf_raddr`=0.
  - FSM=IDLE, k=0, `prev_instr`=0.
- Trigger in cycle T: `trace_valid`=`trace_hold`=1 from edge T+1.
- `trace_hold` is registered and asserts one cycle after the IR change. The CPU must not write the regfile in the cycle after an IR load (true for the fetch/decode step of the multicycle CPU).
- With `trace_ready` tied high, a frame occupies 34 cycles (35 with the sequence feature). `trace_hold` deasserts on the edge accepting the last word.
- A new trigger is evaluated the cycle after return to IDLE.
- `trace_data` in PC/INSTR comes from registers. In REGS it is a combinational passthrough of `rf_rdata`.

## Configuration
- `COMMIT_TRACE_SEQ_EN` defined:
  - A SEQ state is inserted before PC, carrying word `{16'hA5A5, seq[15:0]}`.
  - `seq` is a 16-bit frame counter, reset 0, incremented on acceptance of each SEQ word, wrapping 0xFFFF→0x0000.
  - Frame length becomes 35.
- Not defined: no SEQ state, no counter; frame length 34.

## Test plan
- Reset, then `ir_out`=0x20080005, `pc_out`=0x00400008, `trace_ready`=1 → frame is `00400000`, `00000000`, then r0..r31. `trace_last` on word 34. `trace_hold` high for exactly 34 cycles.
- `ir_out` held 0x00000000 after reset → no frame, `trace_valid` stays 0. Then change to 0x00000001 → one frame.
- `trace_ready` toggled 1-0-0-1 pattern mid-REGS → each word is presented unchanged until accepted, no word is skipped or duplicated, and k advances only on handshake.
- `ir_out` changes while `trace_en`=0 → no frame. Set `trace_en`=1 with `ir_out` still different from `prev_instr` → frame starts next edge.
- `reset` pulled low at word 10 → all outputs 0 asynchronously. After release, the first new IR value produces a complete frame.
- With `COMMIT_TRACE_SEQ_EN`, three frames → first words `A5A50000`, `A5A50001`, `A5A50002`. Force `seq`=0xFFFF → next frame `A5A5FFFF`, then `A5A50000`.
